// File: rtl/fifo_rd_to_axis.sv
// fifo_rd_to_axis: fifo read port (one-cycle latency) to AXI-Stream master.
// Credit-driven rd_en feeds a 2-entry buffer; optional fixed-length tlast.
module fifo_rd_to_axis #(
    parameter int BYTE_WIDTH = 4,
    parameter int PACKET_LEN = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    aclk,
    input  logic                    arstn,
    output logic                    rd_en,
    input  logic                    rd_valid,
    input  logic [BYTE_WIDTH*8-1:0] rd_data,
    input  logic                    rd_empty,
    output logic [BYTE_WIDTH*8-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    rd_err
);
    localparam int W = BYTE_WIDTH * 8;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT =
        (PACKET_LEN > 0) ? CNT_WIDTH'(PACKET_LEN - 1) : '0;

    logic [1:0]           occ;
    logic                 inflight;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [W-1:0]         mem [2];
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic                 pop;
    logic                 capture;
    logic                 credit;

    // Stream outputs come only from buffer/occupancy/counter registers
    always_comb begin
        m_axis_tvalid = (occ != 2'd0);
        m_axis_tdata  = mem[rd_ptr];
        m_axis_tlast  = 1'b0;
        if (PACKET_LEN > 0)
            m_axis_tlast = m_axis_tvalid & (beat_cnt == LAST_BEAT);
    end

    // Handshake decode and read credit; a pop frees a slot this cycle
    always_comb begin
        pop     = m_axis_tvalid & m_axis_tready;
        capture = rd_valid & inflight;
        credit  = ({1'b0, occ} + {2'b0, inflight}) < 3'd2;
        rd_en   = arstn & ~rd_empty & (credit | pop);
    end

    // Occupancy, pointers and the one-deep in-flight tracker
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (capture)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({capture, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Buffer storage, written at the tail on each accepted read return
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (capture) begin
            mem[wr_ptr] <= rd_data;
        end
    end

    // Sticky flag for read data that arrives with nothing in flight
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn)
            rd_err <= 1'b0;
        else if (rd_valid && !inflight)
            rd_err <= 1'b1;
    end

    // Beat counter for tlast framing, wraps on the last beat of a packet
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn)
            beat_cnt <= '0;
        else if (pop && (PACKET_LEN > 0))
            beat_cnt <= m_axis_tlast ? '0 : beat_cnt + CNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_fifo_rd_to_axis.sv
// tb_fifo_rd_to_axis: directed bench with a fifo model and a stream monitor.
// Main DUT frames 4-beat packets; a second DUT frames single-beat packets.
module tb_fifo_rd_to_axis;
  localparam int BW = 4;
  localparam int W  = BW * 8;

  int n_asrt = 0;
  int n_fail = 0;

  logic aclk  = 1'b0;
  logic arstn = 1'b0;

  logic         rd_en;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic         rd_empty;
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready = 1'b0;
  logic         rd_err;

  logic         rd_en1;
  logic [W-1:0] tdata1;
  logic         tvalid1;
  logic         tlast1;
  logic         tready1 = 1'b0;
  logic         rd_err1;
  logic         rd_empty1 = 1'b0;

  logic [W-1:0] fmem [256];
  int           fhead  = 0;
  int           ftail  = 0;
  bit           fflush = 1'b1;
  bit           mvalid = 1'b0;
  logic [W-1:0] mdata  = '0;
  bit           inj    = 1'b0;

  bit           rv1   = 1'b0;
  logic [W-1:0] rdat1 = '0;
  logic [W-1:0] cnt1  = '0;

  int           nbuf  = 0;
  int           bcnt  = 0;
  int           ehead = 0;
  int           nlast = 0;
  int           npop  = 0;
  logic [W-1:0] e1    = '0;
  bit           hold  = 1'b0;
  logic [W-1:0] hdata = '0;
  logic         hlast = 1'b0;

  assign rd_valid = mvalid | inj;
  assign rd_data  = mdata;
  assign rd_empty = (fhead == ftail);

  fifo_rd_to_axis #(.BYTE_WIDTH(BW), .PACKET_LEN(4)) u_dut (
    .aclk          (aclk),
    .arstn         (arstn),
    .rd_en         (rd_en),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_empty      (rd_empty),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tlast  (tlast),
    .m_axis_tready (tready),
    .rd_err        (rd_err)
  );

  fifo_rd_to_axis #(.BYTE_WIDTH(BW), .PACKET_LEN(1)) u_dut1 (
    .aclk          (aclk),
    .arstn         (arstn),
    .rd_en         (rd_en1),
    .rd_valid      (rv1),
    .rd_data       (rdat1),
    .rd_empty      (rd_empty1),
    .m_axis_tdata  (tdata1),
    .m_axis_tvalid (tvalid1),
    .m_axis_tlast  (tlast1),
    .m_axis_tready (tready1),
    .rd_err        (rd_err1)
  );

  always #5 aclk = ~aclk;

  task automatic fail(input string t,
                      input logic [W-1:0] o,
                      input logic [W-1:0] e);
    n_fail++;
    $error("FAIL %s: got 0x%0h expected 0x%0h", t, o, e);
  endtask

  always @(posedge aclk) begin
    if (fflush) begin
      fhead  <= ftail;
      mvalid <= 1'b0;
    end else begin
      mvalid <= rd_en;
      if (rd_en) begin
        mdata <= fmem[fhead];
        fhead <= fhead + 1;
      end
    end
  end

  always @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      rv1  <= 1'b0;
      cnt1 <= '0;
    end else begin
      rv1 <= rd_en1;
      if (rd_en1) begin
        rdat1 <= cnt1;
        cnt1  <= cnt1 + 1;
      end
    end
  end

  always @(negedge aclk) begin
    if (!arstn) begin
      nbuf = 0;
      bcnt = 0;
      hold = 1'b0;
      e1   = '0;
      if (fflush)
        ehead = ftail;
    end else begin
      n_asrt++;
      if (tvalid !== (nbuf != 0))
        fail("tvalid_vs_occ", tvalid, (nbuf != 0));
      n_asrt++;
      if (nbuf > 2)
        fail("occ_max", nbuf, 2);
      if (nbuf == 2 && !tready) begin
        n_asrt++;
        if (rd_en !== 1'b0)
          fail("rd_en_full", rd_en, 1'b0);
      end
      if (!tvalid) begin
        n_asrt++;
        if (tlast !== 1'b0)
          fail("tlast_idle", tlast, 1'b0);
      end
      if (hold) begin
        n_asrt++;
        if (tvalid !== 1'b1)
          fail("hold_valid", tvalid, 1'b1);
        n_asrt++;
        if (tdata !== hdata)
          fail("hold_data", tdata, hdata);
        n_asrt++;
        if (tlast !== hlast)
          fail("hold_last", tlast, hlast);
      end
      if (tvalid && tready) begin
        n_asrt++;
        if (ehead >= fhead)
          fail("no_dup", ehead, fhead);
        n_asrt++;
        if (tdata !== fmem[ehead])
          fail("beat_data", tdata, fmem[ehead]);
        n_asrt++;
        if (tlast !== (bcnt == 3))
          fail("beat_last", tlast, (bcnt == 3));
        if (tlast)
          nlast++;
        bcnt = (bcnt + 1) % 4;
        ehead++;
        npop++;
      end
      hold  = tvalid && !tready;
      hdata = tdata;
      hlast = tlast;
      nbuf  = nbuf + int'(mvalid) - int'(tvalid && tready);

      n_asrt++;
      if (tlast1 !== tvalid1)
        fail("len1_last", tlast1, tvalid1);
      n_asrt++;
      if (rd_err1 !== 1'b0)
        fail("len1_err", rd_err1, 1'b0);
      if (tvalid1 && tready1) begin
        n_asrt++;
        if (tdata1 !== e1)
          fail("len1_data", tdata1, e1);
        e1 = e1 + 1;
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
    tready1 = 1'($urandom_range(0, 1));
  endtask

  task automatic load(input logic [W-1:0] v);
    fmem[ftail] = v;
    ftail++;
  endtask

  task automatic drain(input int lim, input int mode);
    int c = 0;
    while (ehead != ftail && c < lim) begin
      case (mode)
        0:       tready = 1'b1;
        1:       tready = 1'($urandom_range(0, 1));
        default: tready = (c % 4 == 0) || (c % 4 == 3);
      endcase
      step();
      c++;
    end
    n_asrt++;
    if (ehead !== ftail)
      fail("drain", ehead, ftail);
  endtask

  initial begin
    int base;
    int c;

    step();
    fflush = 1'b0;
    for (int i = 1; i <= 16; i++)
      load(W'(i));

    for (int i = 0; i < 4; i++) begin
      step();
      n_asrt++;
      if (rd_en !== 1'b0)
        fail("rst_rd_en", rd_en, 1'b0);
      n_asrt++;
      if (tvalid !== 1'b0)
        fail("rst_tvalid", tvalid, 1'b0);
      n_asrt++;
      if (tlast !== 1'b0)
        fail("rst_tlast", tlast, 1'b0);
      n_asrt++;
      if (rd_err !== 1'b0)
        fail("rst_rd_err", rd_err, 1'b0);
      n_asrt++;
      if (tdata !== '0)
        fail("rst_tdata", tdata, '0);
      n_asrt++;
      if (rd_en1 !== 1'b0)
        fail("rst_rd_en1", rd_en1, 1'b0);
    end

    arstn  = 1'b1;
    tready = 1'b1;
    #1;
    n_asrt++;
    if (rd_en !== 1'b1)
      fail("first_rd_en", rd_en, 1'b1);
    step();
    n_asrt++;
    if (tvalid !== 1'b0)
      fail("latency_n1", tvalid, 1'b0);
    step();
    for (int i = 1; i <= 16; i++) begin
      n_asrt++;
      if (tvalid !== 1'b1)
        fail("stream_valid", tvalid, 1'b1);
      n_asrt++;
      if (tdata !== W'(i))
        fail("stream_data", tdata, W'(i));
      step();
    end
    n_asrt++;
    if (tvalid !== 1'b0)
      fail("stream_done", tvalid, 1'b0);

    for (int i = 0; i < 32; i++)
      load(W'(32'h100 + i));
    #1;
    n_asrt++;
    if (rd_en !== 1'b1)
      fail("rd_en_refill", rd_en, 1'b1);
    drain(400, 2);

    base = nlast;
    for (int i = 0; i < 12; i++)
      load(W'(32'h200 + i));
    drain(400, 1);
    n_asrt++;
    if (nlast - base !== 3)
      fail("frame_tlast_cnt", nlast - base, 3);

    tready = 1'b1;
    step();
    step();
    n_asrt++;
    if (tvalid !== 1'b0)
      fail("viol_pre_valid", tvalid, 1'b0);
    inj = 1'b1;
    step();
    inj = 1'b0;
    n_asrt++;
    if (rd_err !== 1'b1)
      fail("viol_err", rd_err, 1'b1);
    n_asrt++;
    if (tvalid !== 1'b0)
      fail("viol_valid", tvalid, 1'b0);
    step();
    step();
    step();
    n_asrt++;
    if (rd_err !== 1'b1)
      fail("viol_sticky", rd_err, 1'b1);
    n_asrt++;
    if (tvalid !== 1'b0)
      fail("viol_no_beat", tvalid, 1'b0);

    for (int i = 0; i < 6; i++)
      load(W'(32'h300 + i));
    base   = npop;
    tready = 1'b1;
    c      = 0;
    while (npop - base < 2 && c < 50) begin
      step();
      c++;
    end
    tready = 1'b0;
    n_asrt++;
    if (npop - base !== 2)
      fail("mid_pops", npop - base, 2);
    step();
    step();
    step();
    n_asrt++;
    if (tvalid !== 1'b1)
      fail("mid_full_valid", tvalid, 1'b1);
    n_asrt++;
    if (rd_en !== 1'b0)
      fail("mid_full_rd_en", rd_en, 1'b0);
    n_asrt++;
    if (tdata !== W'(32'h302))
      fail("mid_full_head", tdata, W'(32'h302));
    #2;
    arstn  = 1'b0;
    fflush = 1'b1;
    #1;
    n_asrt++;
    if (tvalid !== 1'b0)
      fail("mid_rst_valid", tvalid, 1'b0);
    n_asrt++;
    if (tdata !== '0)
      fail("mid_rst_data", tdata, '0);
    n_asrt++;
    if (rd_en !== 1'b0)
      fail("mid_rst_rd_en", rd_en, 1'b0);
    step();
    step();
    n_asrt++;
    if (rd_err !== 1'b0)
      fail("mid_rst_err", rd_err, 1'b0);
    fflush = 1'b0;
    for (int i = 0; i < 4; i++)
      load(W'(32'h400 + i));
    base  = nlast;
    arstn = 1'b1;
    drain(50, 0);
    n_asrt++;
    if (nlast - base !== 1)
      fail("mid_new_packet", nlast - base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fifo_rd_to_axis.md
Name: fifo_rd_to_axis

Overview:
- Downstream companion to the fifo block's read interface (FWFT=0, one-cycle read latency).
- Issues fifo rd_en under credit control and captures rd_valid/rd_data into a 2-entry output buffer.
- Presents the data as an AXI-Stream master with full valid/ready semantics and optional fixed-length tlast framing.
- Sits between the fifo read port and any AXIS consumer, e.g. a DMA or serializer, at full one-beat-per-cycle throughput.

Parameters:
- BYTE_WIDTH, 4: data width in bytes; rd_data and m_axis_tdata are BYTE_WIDTH*8 bits.
- PACKET_LEN, 0: beats per packet for tlast generation; 0 means tlast is held at 0.
- CNT_WIDTH, 16: width of the beat counter; PACKET_LEN must be less than 2**CNT_WIDTH.

Ports:
- aclk  in  1  clock for all logic.
- arstn  in  1  asynchronous active-low reset.
- rd_en  out  1  fifo read request.
- rd_valid  in  1  fifo read data valid; asserted the cycle after an accepted rd_en.
- rd_data  in  BYTE_WIDTH*8  fifo read data.
- rd_empty  in  1  fifo empty flag.
- m_axis_tdata  out  BYTE_WIDTH*8  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tready  in  1  stream ready.
- rd_err  out  1  sticky flag: rd_valid received with no read in flight.

Behaviour:
- Decided interface: one clock, aclk; reset arstn is asynchronous and active-low. On assertion, all of the following clear to 0 immediately:
  - occupancy counter occ (range 0..2)
  - inflight flag
  - beat counter
  - buffer pointers
  - rd_err
  - m_axis_tvalid, m_axis_tlast, m_axis_tdata
  - rd_en, held 0 while arstn=0
- pop = m_axis_tvalid & m_axis_tready.
- rd_en = ~rd_empty & ((occ + inflight < 2) | pop), combinational.
  - The path from m_axis_tready to rd_en is intentional.
  - The credit scheme guarantees the buffer never overflows.
- inflight register: set to rd_en every cycle.
- Capture: when rd_valid=1 and inflight=1, write rd_data into the buffer tail; occ increments.
  - Simultaneous capture and pop leaves occ unchanged.
- Protocol violation: when rd_valid=1 and inflight=0, the data is dropped and rd_err sets. rd_err stays 1 until reset.
- Buffer: 2-entry circular buffer with 1-bit read and write pointers.
  - m_axis_tdata = head entry.
  - m_axis_tvalid = (occ != 0).
  - Outputs are driven from registers; no rd_data-to-tdata combinational path.
- AXIS rules:
  - Once m_axis_tvalid=1, tvalid, tdata and tlast hold stable until pop.
  - tvalid never depends on tready.
- Latency: rd_en high in cycle N, rd_valid in N+1, m_axis_tvalid in N+2 (2 cycles).
- Throughput: with rd_empty=0 and tready=1 continuously, one beat per cycle in steady state.
- Backpressure, tready=0:
  - At most 2 words are held: occ=2, inflight=0, rd_en=0.
  - rd_en resumes in the same cycle tready rises.
- tlast, PACKET_LEN>0:
  - beat_cnt increments on each pop.
  - m_axis_tlast = (beat_cnt == PACKET_LEN-1) & m_axis_tvalid.
  - On a pop with tlast=1, beat_cnt wraps to 0.
  - PACKET_LEN=1 gives tlast on every beat.
- tlast, PACKET_LEN=0: tlast=0 and the counter is unused.
- Empty fifo: rd_en=0 and buffered data still drains. When the fifo refills, rd_en reasserts the same cycle rd_empty falls (given credit).
- Reset mid-packet: buffered words and the in-flight word are discarded and beat_cnt returns to 0. After release, the first beat starts a new packet.

Test Plan:
- Reset check: arstn=0 for 4 cycles with rd_empty=0 -> rd_en=0, m_axis_tvalid=0, m_axis_tlast=0, rd_err=0. First rd_en is asserted in the first cycle after release.
- Streaming: fifo model loaded with 0x00000001..0x00000010, tready=1 constantly -> m_axis_tvalid first rises 2 cycles after the first rd_en. 16 beats appear in order on consecutive cycles with no gaps.
- Backpressure: tready toggles 1,0,0,1 repeating over 32 words -> no loss or duplication; tdata is stable while tvalid=1 and tready=0. rd_en=0 whenever occ=2 and tready=0; occ never exceeds 2.
- Framing: PACKET_LEN=4, 12 words, tready random -> tlast=1 exactly on beats 4, 8 and 12. Repeat with PACKET_LEN=1 -> tlast on every beat.
- Violation: rd_valid pulsed with rd_empty=1 and no prior rd_en -> rd_err=1 the next cycle and stays 1. No stream beat is produced and occ is unchanged.
- Mid-packet reset: PACKET_LEN=4, assert arstn after beat 2 with occ=2 -> tvalid drops asynchronously. After release and 4 new words, tlast falls on the 4th new beat.
